// File: rtl/segre_wb_stage.sv
// ---------------------------------------------------------------------------
// segre_wb_stage
//   Writeback stage of the segre pipeline. It holds the MEM/WB registers and
//   from them drives the register-file write port, the WB->EX forwarding
//   entry, a one-shot fetch redirect for taken branches/jumps, a retire pulse
//   and the instret/cycle counters.
//
//   Ports
//     clk_i, rsn_i        clock (rising edge), async active-low reset
//     valid_mem_i ...     MEM-stage instruction: valid, result, rf write
//                         enable/address, taken-branch flag, redirect target
//     block_wb_i          hold the WB registers (stall)
//     inject_nops_i       capture a bubble instead of the MEM instruction
//     rf_*_o              register-file write port
//     fwd_*_o             forwarding entry towards EX
//     tkbr_o, new_pc_o    one-cycle redirect pulse and its target
//     retire_o            one pulse per retired instruction
//     instret_o, cycle_o  retired-instruction and cycle counters
//
//   Every output is a function of registers only; there is no combinational
//   path from any input to any output.
// ---------------------------------------------------------------------------
module segre_wb_stage #(
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int ADDR_SIZE = 32,
    parameter int CNT_SIZE  = 64
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 valid_mem_i,
    input  logic [WORD_SIZE-1:0] op_res_i,
    input  logic                 rf_we_i,
    input  logic [REG_SIZE-1:0]  rf_waddr_i,
    input  logic                 tkbr_i,
    input  logic [ADDR_SIZE-1:0] new_pc_i,
    input  logic                 block_wb_i,
    input  logic                 inject_nops_i,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic [WORD_SIZE-1:0] rf_data_o,
    output logic                 fwd_valid_o,
    output logic [REG_SIZE-1:0]  fwd_addr_o,
    output logic [WORD_SIZE-1:0] fwd_data_o,
    output logic                 tkbr_o,
    output logic [ADDR_SIZE-1:0] new_pc_o,
    output logic                 retire_o,
    output logic [CNT_SIZE-1:0]  instret_o,
    output logic [CNT_SIZE-1:0]  cycle_o
);

    logic                 r_valid_q;
    logic                 r_rf_we_q;
    logic                 r_tkbr_q;
    // High only in the first cycle an instruction sits in WB; gates every
    // one-shot architectural effect so a held instruction acts exactly once.
    logic                 r_fresh_q;
    logic [REG_SIZE-1:0]  r_rf_waddr_q;
    logic [WORD_SIZE-1:0] r_op_res_q;
    logic [ADDR_SIZE-1:0] r_new_pc_q;
    logic [CNT_SIZE-1:0]  r_instret;
    logic [CNT_SIZE-1:0]  r_cycle;

    logic w_live;
    logic w_wr_ok;

    assign w_live  = r_fresh_q & r_valid_q;
    // x0 is hard-wired to zero: never written, never forwarded.
    assign w_wr_ok = r_valid_q & r_rf_we_q & (r_rf_waddr_q != '0);

    // MEM/WB registers. Block has priority over inject, so a stalled
    // instruction survives a simultaneous bubble request.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_valid_q    <= 1'b0;
            r_rf_we_q    <= 1'b0;
            r_tkbr_q     <= 1'b0;
            r_fresh_q    <= 1'b0;
            r_rf_waddr_q <= '0;
            r_op_res_q   <= '0;
            r_new_pc_q   <= '0;
        end else if (block_wb_i) begin
            r_fresh_q    <= 1'b0;
        end else if (inject_nops_i) begin
            // Data registers are left as they are; nothing reads them
            // while the control bits are clear.
            r_valid_q    <= 1'b0;
            r_rf_we_q    <= 1'b0;
            r_tkbr_q     <= 1'b0;
            r_fresh_q    <= 1'b0;
        end else begin
            r_valid_q    <= valid_mem_i;
            r_rf_we_q    <= rf_we_i;
            r_tkbr_q     <= tkbr_i;
            r_fresh_q    <= valid_mem_i;
            r_rf_waddr_q <= rf_waddr_i;
            r_op_res_q   <= op_res_i;
            r_new_pc_q   <= new_pc_i;
        end
    end

    // Counters wrap silently at 2^CNT_SIZE.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_instret <= '0;
            r_cycle   <= '0;
        end else begin
            r_instret <= r_instret + CNT_SIZE'(w_live);
            r_cycle   <= r_cycle + CNT_SIZE'(1);
        end
    end

    assign rf_we_o     = r_fresh_q & w_wr_ok;
    assign rf_waddr_o  = r_rf_waddr_q;
    assign rf_data_o   = r_op_res_q;

    // Forwarding stays valid while held: the value is still the youngest
    // definition of that register.
    assign fwd_valid_o = w_wr_ok;
    assign fwd_addr_o  = r_rf_waddr_q;
    assign fwd_data_o  = r_op_res_q;

    assign tkbr_o      = w_live & r_tkbr_q;
    assign new_pc_o    = r_new_pc_q;

    assign retire_o    = w_live;
    assign instret_o   = r_instret;
    assign cycle_o     = r_cycle;

endmodule

// File: doc/segre_wb_stage.md
Name: segre_wb_stage

Overview:
Writeback stage, directly downstream of the memory stage. Holds the MEM/WB decoupling registers and drives the register-file write port and the WB→EX forwarding path. Issues a one-shot PC redirect for taken branches/jumps and keeps retired-instruction and cycle counters. Each instruction's architectural effects occur exactly once, even when the stage is held by block_wb_i.

Parameters:
WORD_SIZE, 32, data/result width
REG_SIZE, 5, register-file address width
ADDR_SIZE, 32, PC width
CNT_SIZE, 64, width of retire and cycle counters

Ports:
clk_i  in  1  clock, rising edge
rsn_i  in  1  asynchronous active-low reset
valid_mem_i  in  1  MEM stage presents a valid instruction
op_res_i  in  WORD_SIZE  result from MEM stage (load data, ALU result or link address)
rf_we_i  in  1  instruction writes the register file
rf_waddr_i  in  REG_SIZE  destination register
tkbr_i  in  1  instruction is a taken branch/jump
new_pc_i  in  ADDR_SIZE  redirect target
block_wb_i  in  1  hold the WB registers
inject_nops_i  in  1  capture a bubble instead of the input
rf_we_o  out  1  register-file write enable
rf_waddr_o  out  REG_SIZE  register-file write address
rf_data_o  out  WORD_SIZE  register-file write data
fwd_valid_o  out  1  forwarding entry valid
fwd_addr_o  out  REG_SIZE  forwarded destination register
fwd_data_o  out  WORD_SIZE  forwarded value
tkbr_o  out  1  one-cycle redirect pulse to fetch
new_pc_o  out  ADDR_SIZE  redirect target
retire_o  out  1  one-cycle pulse per retired instruction
instret_o  out  CNT_SIZE  retired-instruction count
cycle_o  out  CNT_SIZE  cycles since reset

Behaviour:
- Clocking: one clock, clk_i. Reset rsn_i is asynchronous, active-low.
- Reset (asynchronous, immediate):
  - Clears valid_q, rf_we_q, tkbr_q, fresh_q, instret and cycle.
  - All outputs read 0, including the data/address outputs (their _q registers are also reset).
- Register update, at each rising edge, in priority order:
  - block_wb_i=1: all _q registers hold; fresh_q←0.
  - else inject_nops_i=1: valid_q, rf_we_q, tkbr_q ←0; fresh_q←0; data registers don't-care.
  - else: capture all inputs; fresh_q←valid_mem_i.
- fresh_q is 1 exactly in the first cycle an instruction occupies WB, and 0 while it is held.
- Write port:
  - rf_we_o = fresh_q & valid_q & rf_we_q & (rf_waddr_q≠0).
  - rf_waddr_o = rf_waddr_q; rf_data_o = op_res_q.
  - x0 is never written.
- Forwarding (not gated by fresh_q; stays valid while held):
  - fwd_valid_o = valid_q & rf_we_q & (rf_waddr_q≠0).
  - fwd_addr_o = rf_waddr_q; fwd_data_o = op_res_q.
- Redirect:
  - tkbr_o = fresh_q & valid_q & tkbr_q; new_pc_o = new_pc_q.
  - Exactly one pulse per instruction, even if block_wb_i holds it for N cycles.
- Retire: retire_o = fresh_q & valid_q.
- Counters:
  - instret increments by 1 in each cycle retire_o=1, visible on instret_o the following cycle.
  - cycle increments every cycle after reset release.
  - Both wrap from 2^CNT_SIZE−1 to 0 with no flag.
- Latency: an input captured at edge k appears on all outputs during cycle k→k+1; there is no combinational path from any input to any output.
- Simultaneous block_wb_i and inject_nops_i: block wins and the instruction is held.
- Inject while an instruction is held: that instruction is dropped at the next unblocked edge, having already produced its single write, redirect and retire.
- valid_mem_i=0 with rf_we_i=1 or tkbr_i=1: captured, but no write, redirect or retire occurs.
- Reset asserted mid-hold: the instruction is discarded; counters return to 0.

Test Plan:
1. Reset, then 3 back-to-back valid ALU ops writing x1=5, x2=7, x3=9 → rf_we_o pulses 3 consecutive cycles with the matching addr/data; instret_o=3 one cycle after the last retire.
2. Valid op with rf_waddr=0, op_res=0xDEAD → rf_we_o=0, fwd_valid_o=0, retire_o=1.
3. Taken jump with new_pc=0x0000_0100, then block_wb_i held 4 cycles → tkbr_o high exactly 1 cycle with new_pc_o=0x100; fwd_valid_o stays 1 for all 5 cycles; instret +1 only.
4. block_wb_i=1 and inject_nops_i=1 in the same cycle with a valid op in WB → op held, then inject alone → valid_q=0 next cycle; no second rf_we_o pulse.
5. Preload instret to 2^64−1 (force), retire one op → instret_o=0.
6. Assert rsn_i low asynchronously mid-cycle while a valid write op is held → rf_we_o, fwd_valid_o, tkbr_o, retire_o, instret_o and cycle_o drop to 0 immediately, without waiting for a clock edge.
